// File: rtl/dmem_port_arbiter_pkg.sv
// mem_arb_pkg: FSM state encodings and default bus widths for the memory port arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: req/ack memory bus between the arbiter (master) and the unified memory (slave)
interface dmem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, input mem_ack_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// arb_sat_counter: 32-bit counter with enable and synchronous load that sticks at all-ones
module arb_sat_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_cnt
);
  logic [31:0] r_cnt;
  always_ff @(posedge clk_i)
    if (rst_i) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && !(&r_cnt)) r_cnt <= r_cnt + 32'd1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one memory port between IF fetches and MEM loads/stores, data first.
// Define ARB_PERF_CNT_EN to build the saturating stall-cycle counter behind perf_stall_cnt_o.
module dmem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              stall_o,
  dmem_port_arbiter_if.master mem,
  output logic [31:0]       perf_stall_cnt_o
);
  state_t            r_state, w_next;
  logic              r_req, r_we, r_if_valid, r_dm_valid, r_dm_done, r_if_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic              w_dm_pend, w_start_dm, w_start_if, w_ack_dm, w_ack_if;
  always_comb begin
    w_dm_pend  = dm_read_i | dm_write_i;
    stall_o    = (w_dm_pend & ~r_dm_done) | (if_req_i & ~r_if_done);
    w_start_dm = (r_state == ST_IDLE) & w_dm_pend & ~r_dm_done;
    w_start_if = (r_state == ST_IDLE) & ~w_start_dm & if_req_i & ~r_if_done;
    w_ack_dm   = (r_state == ST_DATA) & mem.mem_ack_i;
    w_ack_if   = (r_state == ST_INST) & mem.mem_ack_i;
    w_next     = w_start_dm ? ST_DATA : w_start_if ? ST_INST : (w_ack_dm | w_ack_if) ? ST_IDLE : r_state;
  end
  always_ff @(posedge clk_i)
    r_state <= rst_i ? ST_IDLE : w_next;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_dm_done  <= 1'b0;
      r_if_done  <= 1'b0;
    end else begin
      r_if_valid <= w_ack_if;
      r_dm_valid <= w_ack_dm;
      r_dm_done  <= w_ack_dm | (r_dm_done & stall_o);
      r_if_done  <= w_ack_if | (r_if_done & stall_o);
      if (w_start_dm) begin
        r_req   <= 1'b1;
        r_we    <= dm_write_i;
        r_addr  <= dm_addr_i;
        r_wdata <= dm_wdata_i;
      end else if (w_start_if) begin
        r_req  <= 1'b1;
        r_we   <= 1'b0;
        r_addr <= if_addr_i;
      end else if (w_ack_dm | w_ack_if) r_req <= 1'b0;
      if (w_ack_dm & ~r_we) r_dm_rdata <= mem.mem_rdata_i;
      if (w_ack_if) r_if_rdata <= mem.mem_rdata_i;
    end
  end
  assign mem.mem_req_o   = r_req;
  assign mem.mem_we_o    = r_we;
  assign mem.mem_addr_o  = r_addr;
  assign mem.mem_wdata_o = r_wdata;
  assign if_rdata_o      = r_if_rdata;
  assign if_valid_o      = r_if_valid;
  assign dm_rdata_o      = r_dm_rdata;
  assign dm_valid_o      = r_dm_valid;
`ifdef ARB_PERF_CNT_EN
  arb_sat_counter u_perf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_en      (stall_o),
    .i_load    (1'b0),
    .i_load_val(32'd0),
    .o_cnt     (perf_stall_cnt_o)
  );
`else
  assign perf_stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of fetch, load+fetch, store, reset abort and counter saturation
module tb_dmem_port_arbiter;
  import mem_arb_pkg::*;
  logic        clk = 1'b0;
  logic        rst_i, if_req_i, dm_read_i, dm_write_i, if_valid_o, dm_valid_o, stall_o;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, if_rdata_o, dm_rdata_o, perf_stall_cnt_o;
  logic        c_en, c_load;
  logic [31:0] c_val, c_cnt;
  int          n_chk = 0, n_pass = 0;
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .dm_read_i(dm_read_i),
    .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .stall_o(stall_o),
    .mem(bus.master), .perf_stall_cnt_o(perf_stall_cnt_o)
  );
  arb_sat_counter u_cnt (
    .clk_i(clk), .rst_i(rst_i), .i_en(c_en), .i_load(c_load), .i_load_val(c_val), .o_cnt(c_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int sc, rc, dv_cyc, iv_cyc, dv_n;
    logic [31:0] first_addr;
    logic st;
    rst_i = 1; if_req_i = 0; dm_read_i = 0; dm_write_i = 0;
    if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hFFFF_FFFF;
    c_en = 0; c_load = 0; c_val = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("rst_req", bus.mem_req_o, 0);
      chk("rst_we_addr_wdata", {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, 0);
      chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
      chk("rst_valid_stall", {if_valid_o, dm_valid_o, stall_o}, 0);
      chk("rst_perf", perf_stall_cnt_o, 0);
      chk("rst_state", dut.r_state, ST_IDLE);
    end
    rst_i = 0; bus.mem_ack_i = 0;
    if_req_i = 1; if_addr_i = 32'h40; #1;
    chk("f_c0_stall", stall_o, 1);
    chk("f_c0_req", bus.mem_req_o, 0);
    cyc(); #1;
    chk("f_c1_req", {bus.mem_req_o, bus.mem_we_o}, 2'b10);
    chk("f_c1_addr", bus.mem_addr_o, 32'h40);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h00A00093;
    cyc(); bus.mem_ack_i = 0; #1;
    chk("f_c2_valid", {if_valid_o, dm_valid_o, stall_o, bus.mem_req_o}, 4'b1000);
    chk("f_c2_rdata", if_rdata_o, 32'h00A00093);
    cyc(); if_req_i = 0; #1;
    chk("f_c3_valid", if_valid_o, 0);
    rst_i = 1; cyc(); rst_i = 0;
    dm_read_i = 1; dm_addr_i = 32'h100; if_req_i = 1; if_addr_i = 32'h44;
    sc = 0; rc = 0; dv_cyc = -1; iv_cyc = -1; dv_n = 0; first_addr = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      st = stall_o;
      if (st) sc++;
      if (dv_n == 0 && bus.mem_req_o) first_addr = bus.mem_addr_o;
      if (dm_valid_o) begin dv_cyc = c; dv_n++; end
      if (if_valid_o) iv_cyc = c;
      if (bus.mem_req_o) rc++; else rc = 0;
      bus.mem_ack_i = (rc == 3);
      bus.mem_rdata_i = (bus.mem_addr_o == 32'h100) ? 32'h11112222 : 32'h00B00113;
      if (!st) begin dm_read_i = 0; if_req_i = 0; end
      cyc();
    end
    chk("lf_stall_cycles", sc, 8);
    chk("lf_first_addr", first_addr, 32'h100);
    chk("lf_dm_valid_cyc", dv_cyc, 4);
    chk("lf_dm_valid_n", dv_n, 1);
    chk("lf_if_valid_cyc", iv_cyc, 8);
    chk("lf_dm_rdata", dm_rdata_o, 32'h11112222);
    chk("lf_if_rdata", if_rdata_o, 32'h00B00113);
`ifdef ARB_PERF_CNT_EN
    chk("lf_perf", perf_stall_cnt_o, 8);
`else
    chk("lf_perf", perf_stall_cnt_o, 0);
`endif
    bus.mem_ack_i = 0;
    dm_write_i = 1; dm_read_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
    cyc(); #1;
    chk("sw_c1_req_we", {bus.mem_req_o, bus.mem_we_o}, 2'b11);
    chk("sw_c1_bus", {bus.mem_addr_o, bus.mem_wdata_o}, {32'h200, 32'hDEADBEEF});
    dm_addr_i = 32'h300; dm_wdata_i = 32'h0;
    cyc(); #1;
    chk("sw_c2_hold", {bus.mem_addr_o, bus.mem_wdata_o}, {32'h200, 32'hDEADBEEF});
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h12345678;
    cyc(); bus.mem_ack_i = 0; #1;
    chk("sw_c3_valid_stall", {dm_valid_o, stall_o, bus.mem_req_o}, 3'b100);
    chk("sw_c3_rdata", dm_rdata_o, 32'h11112222);
    dm_write_i = 0; dm_read_i = 0;
    cyc(); #1;
    chk("sw_c4_valid", dm_valid_o, 0);
    dm_read_i = 1; dm_addr_i = 32'h500;
    cyc(); #1;
    chk("ra_c1_req", bus.mem_req_o, 1);
    rst_i = 1;
    cyc(); #1;
    chk("ra_c2_req", bus.mem_req_o, 0);
    chk("ra_c2_state", dut.r_state, ST_IDLE);
    rst_i = 0; dm_read_i = 0; bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hFFFF0000;
    cyc(); bus.mem_ack_i = 0; #1;
    chk("ra_c3_valid_req", {dm_valid_o, if_valid_o, bus.mem_req_o}, 0);
    chk("ra_c3_rdata", dm_rdata_o, 32'h0);
    c_load = 1; c_val = 32'hFFFF_FFFD;
    cyc(); c_load = 0; c_en = 1; #1;
    chk("sat_load", c_cnt, 32'hFFFF_FFFD);
    cyc(); #1;
    chk("sat_inc", c_cnt, 32'hFFFF_FFFE);
    cyc(); cyc(); cyc(); #1;
    chk("sat_hold", c_cnt, 32'hFFFF_FFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
